// File: rtl/td4_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : td4_exec_ctrl
// Brief    : Execution controller for the 4-bit TD4 CPU. Conditions the raw
//            front-panel buttons and issues a one-cycle clock-enable pulse
//            to the CPU in HALT / RUN / STEP modes, with a PC breakpoint.
// Revision : 1.0 - initial release
// ============================================================================
module td4_exec_ctrl #(
    parameter int RUN_DIV = 12000000,
    parameter int DEB_CYC = 240000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_run,
    input  logic       btn_step,
    input  logic       btn_halt,
    input  logic       bp_en,
    input  logic [3:0] bp_addr,
    input  logic [3:0] pc,
    output logic       cpu_en,
    output logic [1:0] state,
    output logic       bp_hit,
    output logic [7:0] instr_cnt
);

    localparam int PS_W = $clog2(RUN_DIV);
    localparam int DB_W = $clog2(DEB_CYC + 1);
    localparam logic [PS_W-1:0] C_PS_LAST  = PS_W'(RUN_DIV - 1);
    localparam logic [DB_W-1:0] C_DEB_LAST = DB_W'(DEB_CYC - 1);

    // Button lane indices
    localparam int C_HALT = 0;
    localparam int C_RUN  = 1;
    localparam int C_STEP = 2;

    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning: sync, debounce, rising-edge press pulse
    // ------------------------------------------------------------------
    logic [2:0]      w_btn_raw;
    logic [2:0]      sync0_q, sync1_q;
    logic [DB_W-1:0] deb_cnt_q [3];
    logic [DB_W-1:0] deb_cnt_d [3];
    logic [2:0]      level_q, level_d;
    logic [2:0]      press_q, press_d;

    assign w_btn_raw = {btn_step, btn_run, btn_halt};

    // Debounce: level follows the synced input only after DEB_CYC
    // consecutive cycles of disagreement; any agreement restarts the count.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            level_d[i]   = level_q[i];
            deb_cnt_d[i] = '0;
            if (sync1_q[i] != level_q[i]) begin
                if (deb_cnt_q[i] == C_DEB_LAST) begin
                    level_d[i]   = sync1_q[i];
                    deb_cnt_d[i] = '0;
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DB_W'(1);
                end
            end
        end
        press_d = level_d & ~level_q;
    end

    // Conditioning registers: synchronizer chain, debounce state, press pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0_q <= '0;
            sync1_q <= '0;
            level_q <= '0;
            press_q <= '0;
            for (int i = 0; i < 3; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            sync0_q <= w_btn_raw;
            sync1_q <= sync0_q;
            level_q <= level_d;
            press_q <= press_d;
            for (int i = 0; i < 3; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Execution state machine
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [PS_W-1:0] presc_q, presc_d;
    logic            bp_arm_q, bp_arm_d;
    logic            bp_hit_q, bp_hit_d;
    logic            cpu_en_q, cpu_en_d;
    logic [7:0]      instr_cnt_q, instr_cnt_d;
    logic            w_tick;
    logic            w_bp_match;

    assign w_tick     = (presc_q == C_PS_LAST);
    assign w_bp_match = bp_en && bp_arm_q && (pc == bp_addr);

    // Next-state logic; cpu_en and instr_cnt are decided here so the
    // pulse and its count appear on the same clock edge.
    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        bp_arm_d    = bp_arm_q;
        bp_hit_d    = bp_hit_q;
        cpu_en_d    = 1'b0;
        instr_cnt_d = instr_cnt_q;
        case (state_q)
            ST_HALT: begin
                // halt press has priority and does nothing here, which
                // also swallows any simultaneous run/step press
                if (press_q[C_HALT]) begin
                    state_d = ST_HALT;
                end else if (press_q[C_RUN]) begin
                    state_d  = ST_RUN;
                    presc_d  = '0;
                    bp_arm_d = 1'b0;
                    bp_hit_d = 1'b0;
                end else if (press_q[C_STEP]) begin
                    state_d     = ST_STEP;
                    bp_hit_d    = 1'b0;
                    cpu_en_d    = 1'b1;
                    instr_cnt_d = instr_cnt_q + 8'd1;
                end
            end
            ST_STEP: begin
                // single cycle; the pulse was issued on entry
                state_d = ST_HALT;
            end
            ST_RUN: begin
                if (press_q[C_HALT]) begin
                    state_d = ST_HALT;
                end else if (w_tick) begin
                    presc_d = '0;
                    if (w_bp_match) begin
                        state_d  = ST_HALT;
                        bp_hit_d = 1'b1;
                    end else begin
                        cpu_en_d    = 1'b1;
                        bp_arm_d    = 1'b1;
                        instr_cnt_d = instr_cnt_q + 8'd1;
                    end
                end else begin
                    presc_d = presc_q + PS_W'(1);
                end
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    // FSM state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_HALT;
            presc_q     <= '0;
            bp_arm_q    <= 1'b0;
            bp_hit_q    <= 1'b0;
            cpu_en_q    <= 1'b0;
            instr_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            bp_arm_q    <= bp_arm_d;
            bp_hit_q    <= bp_hit_d;
            cpu_en_q    <= cpu_en_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign cpu_en    = cpu_en_q;
    assign state     = state_q;
    assign bp_hit    = bp_hit_q;
    assign instr_cnt = instr_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_td4_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_td4_exec_ctrl
// Brief    : Directed self-checking bench for td4_exec_ctrl
//            (DEB_CYC=4, RUN_DIV=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_td4_exec_ctrl;

    localparam int C_RUN_DIV = 8;
    localparam int C_DEB_CYC = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_run, btn_step, btn_halt;
    logic       bp_en;
    logic [3:0] bp_addr;
    logic [3:0] pc;
    logic       cpu_en;
    logic [1:0] state;
    logic       bp_hit;
    logic [7:0] instr_cnt;

    td4_exec_ctrl #(
        .RUN_DIV (C_RUN_DIV),
        .DEB_CYC (C_DEB_CYC)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_run   (btn_run),
        .btn_step  (btn_step),
        .btn_halt  (btn_halt),
        .bp_en     (bp_en),
        .bp_addr   (bp_addr),
        .pc        (pc),
        .cpu_en    (cpu_en),
        .state     (state),
        .bp_hit    (bp_hit),
        .instr_cnt (instr_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Monitor state (sampled on the falling edge, away from the active edge)
    int         cyc       = 0;
    int         pulse_cnt = 0;
    int         consec    = 0;
    int         step_cyc  = 0;
    int         run_last  = 0;
    logic       prev_en   = 1'b0;
    int         pulse_t [$];
    logic [3:0] exec_q  [$];

    // CPU program-counter model: advances on every enable pulse
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) pc <= 4'd0;
        else if (cpu_en) pc <= pc + 4'd1;
    end

    // Pulse/state monitor
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (cpu_en) begin
            pulse_cnt <= pulse_cnt + 1;
            pulse_t.push_back(cyc);
            exec_q.push_back(pc);
            if (prev_en) consec <= consec + 1;
        end
        prev_en <= cpu_en;
        if (state == 2'b10) step_cyc <= step_cyc + 1;
        if (state == 2'b01) run_last <= cyc;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic r, input logic s, input logic h);
        btn_run  = r;
        btn_step = s;
        btn_halt = h;
        cycles(10);
        btn_run  = 1'b0;
        btn_step = 1'b0;
        btn_halt = 1'b0;
        cycles(10);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        cycles(2);
    endtask

    int snap, snap2, k;

    initial begin
        rst_n    = 1'b0;
        btn_run  = 1'b0;
        btn_step = 1'b0;
        btn_halt = 1'b0;
        bp_en    = 1'b0;
        bp_addr  = 4'd0;
        do_reset();

        // ---- reset state ----
        check("rst_state", 32'(state), 0);
        check("rst_cpu_en", 32'(cpu_en), 0);
        check("rst_cnt", 32'(instr_cnt), 0);
        check("rst_bp_hit", 32'(bp_hit), 0);
        snap = pulse_cnt;
        cycles(20);
        check("idle_no_pulse", 32'(pulse_cnt - snap), 0);

        // ---- async reset mid-RUN ----
        press(1'b1, 1'b0, 1'b0);
        cycles(10);
        check("run_entered", 32'(state), 1);
        check("run_counted", 32'(instr_cnt != 0), 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_cpu_en", 32'(cpu_en), 0);
        check("arst_state", 32'(state), 0);
        check("arst_cnt", 32'(instr_cnt), 0);
        cycles(2);
        rst_n = 1'b1;
        snap = pulse_cnt;
        cycles(30);
        check("arst_no_pulse", 32'(pulse_cnt - snap), 0);
        check("arst_halted", 32'(state), 0);

        // ---- bouncing step button ----
        snap  = pulse_cnt;
        snap2 = step_cyc;
        for (int i = 0; i < 5; i++) begin
            btn_step = 1'b1;
            cycles(2);
            btn_step = 1'b0;
            cycles(2);
        end
        btn_step = 1'b1;
        cycles(10);
        btn_step = 1'b0;
        cycles(12);
        check("bounce_pulses", 32'(pulse_cnt - snap), 1);
        check("bounce_step_cyc", 32'(step_cyc - snap2), 1);
        check("bounce_cnt", 32'(instr_cnt), 1);
        check("bounce_state", 32'(state), 0);

        // ---- run rate ----
        pulse_t.delete();
        btn_run = 1'b1;
        cycles(40);
        btn_run = 1'b0;
        cycles(10);
        press(1'b0, 1'b0, 1'b1);
        check("rate_state", 32'(state), 0);
        check("rate_npulse", 32'(pulse_t.size() >= 4), 1);
        for (int i = 1; i < pulse_t.size(); i++) begin
            check("rate_gap", 32'(pulse_t[i] - pulse_t[i-1]), C_RUN_DIV);
        end
        if (pulse_t.size() > 0)
            check("rate_no_pulse_in_halt", 32'(pulse_t[pulse_t.size()-1] <= run_last), 1);
        snap = pulse_cnt;
        cycles(30);
        check("rate_quiet", 32'(pulse_cnt - snap), 0);

        // ---- breakpoint ----
        do_reset();
        bp_en   = 1'b1;
        bp_addr = 4'd3;
        exec_q.delete();
        press(1'b1, 1'b0, 1'b0);
        check("bp_running", 32'(state), 1);
        for (k = 0; k < 400 && state != 2'b00; k++) @(negedge clk);
        check("bp_halted", 32'(state), 0);
        check("bp_hit_set", 32'(bp_hit), 1);
        check("bp_cnt", 32'(instr_cnt), 3);
        check("bp_pc", 32'(pc), 3);
        check("bp_nexec", 32'(exec_q.size()), 3);
        for (int i = 0; i < exec_q.size() && i < 3; i++) begin
            check("bp_exec_pc", 32'(exec_q[i]), 32'(i));
        end

        // ---- resume from breakpoint ----
        exec_q.delete();
        press(1'b1, 1'b0, 1'b0);
        check("res_running", 32'(state), 1);
        check("res_bp_clr", 32'(bp_hit), 0);
        for (k = 0; k < 400 && state != 2'b00; k++) @(negedge clk);
        check("res_halted", 32'(state), 0);
        check("res_bp_hit", 32'(bp_hit), 1);
        check("res_nexec", 32'(exec_q.size()), 16);
        if (exec_q.size() >= 2) begin
            check("res_first_pc", 32'(exec_q[0]), 3);
            check("res_second_pc", 32'(exec_q[1]), 4);
        end
        check("res_pc", 32'(pc), 3);
        check("res_cnt", 32'(instr_cnt), 19);

        // ---- simultaneous run+step ----
        bp_en = 1'b0;
        snap2 = step_cyc;
        press(1'b1, 1'b1, 1'b0);
        check("sim_state", 32'(state), 1);
        check("sim_no_step", 32'(step_cyc - snap2), 0);
        check("sim_bp_clr", 32'(bp_hit), 0);
        press(1'b0, 1'b0, 1'b1);
        check("sim_halt", 32'(state), 0);

        // ---- instr_cnt wrap ----
        do_reset();
        for (int i = 0; i < 255; i++) press(1'b0, 1'b1, 1'b0);
        check("wrap_255", 32'(instr_cnt), 255);
        press(1'b0, 1'b1, 1'b0);
        check("wrap_0", 32'(instr_cnt), 0);
        check("wrap_state", 32'(state), 0);

        check("no_back_to_back", 32'(consec), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/td4_exec_ctrl.md
Name: td4_exec_ctrl

Overview:
- Execution controller for the 4-bit TD4 CPU core.
- Converts raw front-panel buttons into a registered one-cycle CPU clock-enable pulse (`cpu_en`), supporting HALT, free-RUN at a divided rate, and single-STEP.
- Halts on a program-counter breakpoint.
- Sits between the board buttons/`clk` and the CPU; the CPU advances its PC and registers only in cycles where `cpu_en`=1.

Parameters:
- RUN_DIV, 12000000, clk cycles per instruction in RUN (>=2).
- DEB_CYC, 240000, clk cycles an input must be stable before its debounced level changes (>=2).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- btn_run  input  1  raw run button, active-high (board inversion done upstream)
- btn_step  input  1  raw single-step button, active-high
- btn_halt  input  1  raw halt button, active-high
- bp_en  input  1  breakpoint enable (level, synchronous to clk)
- bp_addr  input  4  breakpoint PC value
- pc  input  4  current CPU PC (CPU `addr` register)
- cpu_en  output  1  one-cycle instruction enable to CPU
- state  output  2  00=HALT, 01=RUN, 10=STEP
- bp_hit  output  1  sticky: halted by breakpoint
- instr_cnt  output  8  count of issued cpu_en pulses

Behaviour:
- **Reset (rst_n=0, async):**
  - State=HALT; cpu_en=0, bp_hit=0, instr_cnt=0.
  - Prescaler, debounce counters, sync flops, debounced levels and bp_arm all cleared.
  - Reset asserted mid-RUN kills any pending pulse immediately.
- **Input conditioning (per button):**
  - 2-flop synchronizer.
  - Debounce counter: the debounced level takes the synced value only after DEB_CYC consecutive cycles of disagreement; the counter clears on any agreement.
  - Press pulse = 1 cycle on the rising edge of the debounced level.
  - Press latency from raw edge: 2 sync + DEB_CYC + 1 cycles.
- **Press priority when simultaneous:** halt > run > step; lower-priority presses in the same cycle are dropped.
- **HALT:**
  - cpu_en=0.
  - run press -> RUN: prescaler=0, bp_arm=0, bp_hit cleared.
  - step press -> STEP: bp_hit cleared.
  - halt press: no effect.
- **STEP:**
  - Lasts exactly one cycle; cpu_en=1 during it.
  - Next state HALT unconditionally; breakpoint is ignored.
  - Presses arriving during STEP are dropped.
- **RUN:**
  - Prescaler counts 0..RUN_DIV-1 and wraps.
  - Tick cycle = prescaler==RUN_DIV-1.
  - halt press -> HALT next cycle; no pulse that cycle, even if it is a tick.
  - On a tick with bp_en=1, bp_arm=1 and pc==bp_addr -> HALT: no pulse, bp_hit=1.
  - Otherwise a tick gives cpu_en=1 and sets bp_arm=1.
  - bp_arm=0 at RUN entry, so resuming at the breakpoint PC executes that instruction first.
  - run/step presses in RUN are ignored.
- **cpu_en:** registered, never high for two consecutive cycles. Minimum spacing in RUN is RUN_DIV cycles.
- **instr_cnt:** +1 in each cycle cpu_en=1; wraps 255->0.
- **bp_hit:** sticky until the next accepted run or step press, or reset.
- **state:** encoding 11 unreachable; if it ever occurs, next state is HALT.
- **Arithmetic:** prescaler width = clog2(RUN_DIV); debounce counter width = clog2(DEB_CYC+1).

Test Plan (DEB_CYC=4, RUN_DIV=8):
- **Reset:** assert rst_n=0 mid-RUN between clock edges -> cpu_en, state, instr_cnt are 0 before the next clk edge; after release, no pulse until a run press.
- **Bounce:** btn_step toggled every 2 cycles for 20 cycles, then held high 10 cycles -> exactly one cpu_en pulse, state 10 then 00, instr_cnt=1.
- **Run rate:** run press, hold 40 cycles, then halt press -> pulses exactly 8 cycles apart; no pulse after the halt press; state=00.
- **Breakpoint:** bp_en=1, bp_addr=3, PC model increments on cpu_en from 0 -> pulses execute PC 0,1,2, then HALT at pc=3 with bp_hit=1, instr_cnt=3.
- **Resume:** run press -> bp_hit=0; first tick executes PC 3; PC 4 executes at the next tick; no re-halt at 3 until PC wraps 15->0 and returns to 3.
- **Simultaneous/wrap:**
  - run+step pressed together in HALT -> RUN entered, no STEP cycle.
  - instr_cnt preset by 255 steps, then one more step -> instr_cnt=0.
